// File: rtl/fp_mul_arb_pkg.sv
// rtl/fp_mul_arb_pkg.sv - shared widths, types and helpers for the fp_mul arbiter slice
package fp_mul_arb_pkg;

   localparam int FP32_EXP_W  = 8;
   localparam int FP32_FRAC_W = 23;

   typedef logic [31:0] fp32_t;

   // Tag width for n requesters; never below one bit so 1-requester builds stay legal.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fp_mul.sv
// rtl/fp_mul.sv - combinational IEEE-style multiplier, round-to-nearest-even
// Denormal inputs and underflowing results flush to signed zero; overflow saturates to infinity.
module fp_mul #(
   parameter  int EXP_W  = 8,
   parameter  int FRAC_W = 23,
   localparam int W      = 1 + EXP_W + FRAC_W
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] p
);

   localparam int P = 2 * FRAC_W + 2;
   localparam logic [EXP_W+1:0] BIAS = (EXP_W + 2)'((1 << (EXP_W - 1)) - 1);
   localparam logic [EXP_W+1:0] EMAX = (EXP_W + 2)'((1 << EXP_W) - 1);

   logic              sign;
   logic [EXP_W-1:0]  ea, eb;
   logic [FRAC_W-1:0] fa, fb;
   logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic [P-1:0]      prod;
   logic [FRAC_W-1:0] frac, frac_r;
   logic              guard, sticky, rnd, carry;
   logic [EXP_W+1:0]  e_sum, e_r;
   logic              uflow, oflow;

   always_comb begin
      sign   = a[W-1] ^ b[W-1];
      ea     = a[W-2 -: EXP_W];
      eb     = b[W-2 -: EXP_W];
      fa     = a[FRAC_W-1:0];
      fb     = b[FRAC_W-1:0];
      a_zero = (ea == '0);
      b_zero = (eb == '0);
      a_inf  = (ea == '1) && (fa == '0);
      b_inf  = (eb == '1) && (fb == '0);
      a_nan  = (ea == '1) && (fa != '0);
      b_nan  = (eb == '1) && (fb != '0);

      prod  = {{(FRAC_W + 1){1'b0}}, 1'b1, fa} * {{(FRAC_W + 1){1'b0}}, 1'b1, fb};
      e_sum = {2'b00, ea} + {2'b00, eb} - BIAS;

      // Mantissa product is in [1,4); the top bit decides the one-place normalisation.
      if (prod[P-1]) begin
         frac   = prod[P-2 -: FRAC_W];
         guard  = prod[P-2-FRAC_W];
         sticky = |prod[P-3-FRAC_W:0];
      end else begin
         frac   = prod[P-3 -: FRAC_W];
         guard  = prod[P-3-FRAC_W];
         sticky = |prod[P-4-FRAC_W:0];
      end

      rnd             = guard & (sticky | frac[0]);
      {carry, frac_r} = {1'b0, frac} + {{FRAC_W{1'b0}}, rnd};
      e_r   = e_sum + {{(EXP_W + 1){1'b0}}, prod[P-1]} + {{(EXP_W + 1){1'b0}}, carry};
      uflow = e_r[EXP_W+1] || (e_r == '0);
      oflow = !e_r[EXP_W+1] && (e_r >= EMAX);

      if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
         p = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W - 1){1'b0}}};
      else if (a_inf || b_inf || oflow)
         p = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      else if (a_zero || b_zero || uflow)
         p = {sign, {(W - 1){1'b0}}};
      else
         p = {sign, e_r[EXP_W-1:0], frac_r};
   end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with one-hot grant and rotating priority pointer
module rr_arbiter
   import fp_mul_arb_pkg::*;
#(
   parameter  int N  = 4,
   localparam int IW = id_width(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         en,
   output logic [N-1:0] grant
);

   logic [IW-1:0] ptr, ptr_nxt;
   logic          found;
   int            idx;

   // Search starts at ptr and wraps; the winner's successor becomes the next start.
   always_comb begin
      grant   = '0;
      ptr_nxt = ptr;
      found   = 1'b0;
      idx     = 0;
      if (!rst && en) begin
         for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
               grant[idx] = 1'b1;
               found      = 1'b1;
               ptr_nxt    = IW'((idx + 1) % N);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         ptr <= '0;
      else if (found)
         ptr <= ptr_nxt;
   end

endmodule

// File: rtl/fp_mul_arbiter.sv
// rtl/fp_mul_arbiter.sv - one pipelined fp_mul shared round-robin by NUM_REQ requesters
module fp_mul_arbiter
   import fp_mul_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int WIDTH   = 32,
   localparam int ID_W    = id_width(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   output logic                     res_valid,
   output logic [ID_W-1:0]          res_id,
   output logic [WIDTH-1:0]         res_data,
   output logic                     busy
);

   logic [NUM_REQ-1:0] grant;
   logic [WIDTH-1:0]   sel_a, sel_b, a_r, b_r, product;
   logic [ID_W-1:0]    gnt_idx, s1_id;
   logic               s1_valid;

   // The pipeline never stalls, so the arbiter is always enabled.
   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .clk   (clk),
      .rst   (rst),
      .req   (req_valid),
      .en    (1'b1),
      .grant (grant)
   );

   assign req_ready = grant;

   always_comb begin
      sel_a   = '0;
      sel_b   = '0;
      gnt_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_a   = req_a[i*WIDTH +: WIDTH];
            sel_b   = req_b[i*WIDTH +: WIDTH];
            gnt_idx = ID_W'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_id    <= '0;
         a_r      <= '0;
         b_r      <= '0;
      end else begin
         s1_valid <= |grant;
         if (|grant) begin
            s1_id <= gnt_idx;
            a_r   <= sel_a;
            b_r   <= sel_b;
         end
      end
   end

   fp_mul #(.EXP_W(FP32_EXP_W), .FRAC_W(FP32_FRAC_W)) u_mul (
      .a (a_r),
      .b (b_r),
      .p (product)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         res_valid <= 1'b0;
         res_id    <= '0;
         res_data  <= '0;
      end else begin
         res_valid <= s1_valid;
         res_id    <= s1_id;
         if (s1_valid)
            res_data <= product;
      end
   end

   assign busy = s1_valid | res_valid;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// tb/tb_fp_mul_arbiter.sv - directed self-checking bench for fp_mul_arbiter
module tb_fp_mul_arbiter;
   import fp_mul_arb_pkg::*;

   localparam int N = 4;
   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_a, req_b;
   logic           res_valid;
   logic [1:0]     res_id;
   logic [W-1:0]   res_data;
   logic           busy;

   fp32_t op_a[N], op_b[N], prod_exp[N];
   int    n_assert = 0;
   int    n_fail   = 0;

   logic       e1v = 1'b0, e2v = 1'b0;
   logic [1:0] e1id = '0, e2id = '0;
   fp32_t      e1d = '0, e2d = '0;

   always #5 clk = ~clk;

   fp_mul_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .res_valid (res_valid),
      .res_id    (res_id),
      .res_data  (res_data),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_op(input int i, input fp32_t a, input fp32_t b, input fp32_t p);
      op_a[i]     = a;
      op_b[i]     = b;
      prod_exp[i] = p;
   endtask

   // One cycle: drive, check against hand-expected grant and the two-deep result model, clock.
   task automatic cyc(input logic r, input logic [N-1:0] v, input logic [N-1:0] exp_rdy);
      int gi;
      gi        = 0;
      rst       = r;
      req_valid = v;
      for (int i = 0; i < N; i++) begin
         req_a[i*W +: W] = op_a[i];
         req_b[i*W +: W] = op_b[i];
      end
      #1;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("busy", 32'(busy), 32'(e1v | e2v));
      chk("res_valid", 32'(res_valid), 32'(e2v));
      if (e2v) begin
         chk("res_id", 32'(res_id), 32'(e2id));
         chk("res_data", res_data, e2d);
      end
      for (int i = 0; i < N; i++)
         if (exp_rdy[i]) gi = i;
      @(posedge clk);
      if (r) begin
         e1v = 1'b0;
         e2v = 1'b0;
      end else begin
         e2v  = e1v;
         e2id = e1id;
         e2d  = e1d;
         e1v  = |exp_rdy;
         e1id = 2'(gi);
         e1d  = prod_exp[gi];
      end
      #1;
   endtask

   initial begin
      set_op(0, 32'h40000000, 32'h40400000, 32'h40C00000);
      set_op(1, 32'hBF800000, 32'h40800000, 32'hC0800000);
      set_op(2, 32'h3FC00000, 32'h40000000, 32'h40400000);
      set_op(3, 32'h3F800000, 32'h3F800000, 32'h3F800000);
      rst       = 1'b1;
      req_valid = '1;
      for (int i = 0; i < N; i++) begin
         req_a[i*W +: W] = op_a[i];
         req_b[i*W +: W] = op_b[i];
      end
      @(posedge clk);
      #1;

      // Reset held with every requester valid
      cyc(1'b1, 4'b1111, 4'b0000);
      cyc(1'b1, 4'b1111, 4'b0000);
      chk("rst_res_id", 32'(res_id), 32'd0);
      chk("rst_res_data", res_data, 32'd0);
      cyc(1'b0, 4'b1111, 4'b0001);
      cyc(1'b0, 4'b0000, 4'b0000);
      cyc(1'b0, 4'b0000, 4'b0000);
      cyc(1'b0, 4'b0000, 4'b0000);

      // Single request from requester 2: 1.5 * 2.0
      cyc(1'b0, 4'b0100, 4'b0100);
      cyc(1'b0, 4'b0000, 4'b0000);
      cyc(1'b0, 4'b0000, 4'b0000);
      cyc(1'b0, 4'b0000, 4'b0000);

      // Grant to 3, then 1 and 3 alternate; 0 never requests so is never granted
      cyc(1'b0, 4'b1000, 4'b1000);
      cyc(1'b0, 4'b1010, 4'b0010);
      cyc(1'b0, 4'b1010, 4'b1000);
      cyc(1'b0, 4'b1010, 4'b0010);
      cyc(1'b0, 4'b1010, 4'b1000);

      // All four valid: strict rotation 0,1,2,3 twice
      set_op(2, 32'h3F000000, 32'h3F000000, 32'h3E800000);
      for (int k = 0; k < 2; k++) begin
         cyc(1'b0, 4'b1111, 4'b0001);
         cyc(1'b0, 4'b1111, 4'b0010);
         cyc(1'b0, 4'b1111, 4'b0100);
         cyc(1'b0, 4'b1111, 4'b1000);
      end

      // Requester 0 waits behind 2 after a grant to 1, operands held: 1.5 * 1.5
      cyc(1'b0, 4'b0010, 4'b0010);
      set_op(0, 32'h3FC00000, 32'h3FC00000, 32'h40100000);
      cyc(1'b0, 4'b0101, 4'b0100);
      cyc(1'b0, 4'b0001, 4'b0001);

      // Grant to 1 then reset: result for 1 is dropped, pointer restarts at 0
      cyc(1'b0, 4'b0010, 4'b0010);
      cyc(1'b1, 4'b0000, 4'b0000);
      cyc(1'b0, 4'b1110, 4'b0010);
      chk("post_rst_res_data", res_data, 32'd0);
      cyc(1'b0, 4'b0000, 4'b0000);
      cyc(1'b0, 4'b0000, 4'b0000);
      cyc(1'b0, 4'b0000, 4'b0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/fp_mul_arbiter.md
Name: fp_mul_arbiter

Overview:
Shares one fp_mul instance (EXP_W=8, FRAC_W=23) between NUM_REQ requesters with round-robin arbitration. Each requester has a valid/ready request channel. All requesters share one result bus tagged with the requester ID. Operands and product are registered around the multiplier, so the block is fully pipelined: one accepted request per cycle, fixed 2-cycle latency.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
WIDTH, 32, operand/result width; must equal 1+EXP_W+FRAC_W of the fp_mul instance
ID_W, $clog2(NUM_REQ), requester tag width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  NUM_REQ  request valid per requester
req_ready  output  NUM_REQ  grant per requester; one-hot or zero
req_a  input  NUM_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH]
req_b  input  NUM_REQ*WIDTH  operand B; same packing as req_a
res_valid  output  1  result valid, one-cycle pulse per result
res_id  output  ID_W  requester index the result belongs to
res_data  output  WIDTH  product from fp_mul
busy  output  1  high while any request is in the pipeline (stage1 or stage2 valid)

Behaviour:
- Handshake: a transfer occurs for requester i when req_valid[i] & req_ready[i]. req_ready is combinational from req_valid and the RR pointer. A requester must not make req_valid depend on req_ready. After asserting valid, a requester holds valid and its operands stable until the transfer.
- Arbitration: round-robin pointer ptr (ID_W bits), reset 0. The grant goes to the first i with req_valid[i] set, searching ptr, ptr+1, ... NUM_REQ-1, 0, ... (mod NUM_REQ). After a grant to i, ptr <= (i+1) mod NUM_REQ. With no request, ptr holds and req_ready = 0.
- At most one grant per cycle. The pipeline never stalls, so the granted requester is always accepted in the cycle it is granted.
- Stage 1 (edge closing the grant cycle T): s1_valid <= |grant; s1_id <= granted index; a_r/b_r <= granted operands. Operands are captured only when granted, otherwise they hold.
- fp_mul is combinational on a_r/b_r during cycle T+1.
- Stage 2 (edge closing T+1): res_valid <= s1_valid; res_id <= s1_id; res_data <= product, captured only when s1_valid.
- Latency: request transferred in cycle T gives res_valid=1 in cycle T+2. Results are returned in acceptance order.
- There is no backpressure on the result bus. Each requester must accept a result whenever res_valid=1 and res_id matches its own index.
- busy = s1_valid | res_valid.
- Reset values: req_ready=0 (forced while rst=1), res_valid=0, res_id=0, res_data=0, busy=0, ptr=0, s1_valid=0, s1_id=0, a_r=b_r=0.
- Reset mid-operation: all in-flight requests are dropped and no result is produced for them. A requester whose valid stays high through reset is granted again after reset, per the pointer starting at 0.
- Back-to-back: continuous requests from all requesters give grants 0,1,2,3,0,... with one grant per cycle and res_valid high every cycle from T+2.
- Single requester held valid continuously is granted every cycle.
- NaN/Inf/denormal handling is defined by fp_mul; this block passes data through unchanged.

Decomposition:
- Package fp_mul_arb_pkg holds:
  - function id_width(n), used to derive ID_W;
  - localparams FP32_EXP_W=8 and FP32_FRAC_W=23;
  - typedef fp32_t, a logic [31:0].
- Sub-module rr_arbiter #(N): inputs clk, rst, req[N], en; output grant[N], one-hot; internal pointer. It is reusable for other shared units.
- The top level contains rr_arbiter, the operand mux, the two register stages, the fp_mul instance and the tag pipeline.

Test Plan:
1. Reset: rst=1 for 2 cycles with all req_valid=1 -> req_ready=0, res_valid=0, busy=0 throughout. After release, the first grant goes to requester 0.
2. Single request:
   - Stimulus: requester 2 sends a=0x3FC00000 (1.5), b=0x40000000 (2.0) in cycle T.
   - Response: req_ready=4'b0100 in T; res_valid=1, res_id=2, res_data=0x40400000 in T+2 only; busy high in T+1 and T+2.
3. Round-robin fairness:
   - Stimulus: all 4 requesters valid for 8 cycles with distinct operands, e.g. r0 2.0*3.0, r1 -1.0*4.0, r2 0.5*0.5, r3 1.0*1.0.
   - Response: grant order 0,1,2,3,0,1,2,3. res_id follows the same order 2 cycles later, with data 0x40C00000, 0xC0800000, 0x3E800000, 0x3F800000.
4. Pointer advance:
   - Stimulus: requesters 1 and 3 valid continuously after one grant to 3.
   - Response: next grants 1,3,1,3, and requester 0 is never granted.
5. Hold-until-granted: requester 0 valid while 1 was granted last -> requester 0 waits, its operands are held, and the result matches the held operands.
6. Mid-flight reset: grant in cycle T, rst=1 in T+1 -> no res_valid in T+2. After release, busy=0 and ptr restarts at 0.
